// File: rtl/smu_seq_window.sv
// ---------------------------------------------------------------------------
// smu_seq_window
//
// Signal monitoring unit with M independent channels. Each channel walks a
// programmable sequence of up to N stages over the K-bit observable bus p.
// A stage matches when (p & Mask) OP (Cmp & Mask) holds. OP is one of eq,
// neq, unsigned gt or unsigned lt. A stage can carry a timeout window and a
// Last flag that ends the sequence early. Every completed sequence pulses the
// channel trigger and bumps a saturating per-channel event counter.
//
// Configuration is shifted in serially (LSB first) and locked once CFG_SIZE
// bits have been received. Only reset unlocks it.
//
// Optional feature macro: SMU_STICKY_TRIGGER_EN
//   defined   : trigger[m] holds until trigClear[m]. A new fire in the same
//               cycle as a clear keeps the trigger set.
//   undefined : trigger is a one-cycle pulse and trigClear is unused.
//
// Ports
//   clk               in   clock for monitoring and config load
//   rst               in   asynchronous active-low reset
//   p                 in   K-bit observable bus
//   bitstreamSerialIn in   config serial data
//   bitstreamValid    in   qualifies bitstreamSerialIn (one bit per cycle)
//   trigClear         in   M per-channel sticky-trigger clears
//   cfgDone           out  config fully loaded and locked
//   trigger           out  M per-channel triggers
//   smuState          out  current stage per channel, $clog2(N) bits each
//   eventCount        out  saturating fire count per channel, CNT_W bits each
//
// Per-unit config layout (stage s, channel m at [(s*M+m)*UNIT_SIZE +:]),
// LSB first: En(1) CmpSel(2) Last(1) Window(WIN_W) Mask(K) Cmp(K).
// ---------------------------------------------------------------------------
module smu_seq_window #(
  parameter int N     = 4,
  parameter int K     = 8,
  parameter int M     = 4,
  parameter int WIN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [K-1:0]               p,
  input  logic                       bitstreamSerialIn,
  input  logic                       bitstreamValid,
  input  logic [M-1:0]               trigClear,
  output logic                       cfgDone,
  output logic [M-1:0]               trigger,
  output logic [M*$clog2(N)-1:0]     smuState,
  output logic [M*CNT_W-1:0]         eventCount
);

  localparam int UNIT_SIZE = 2*K + WIN_W + 4;
  localparam int CFG_SIZE  = N*M*UNIT_SIZE;
  localparam int S_W       = $clog2(N);
  localparam int BC_W      = $clog2(CFG_SIZE + 1);

  localparam int EN_O   = 0;
  localparam int SEL_O  = 1;
  localparam int LAST_O = 3;
  localparam int WIN_O  = 4;
  localparam int MASK_O = 4 + WIN_W;
  localparam int CMP_O  = 4 + WIN_W + K;

  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_NEQ = 2'b01;
  localparam logic [1:0] CMP_GT  = 2'b10;
  localparam logic [1:0] CMP_LT  = 2'b11;

  // Compare the masked bus against the masked reference with the selected op.
  function automatic logic f_match(input logic [1:0]   sel,
                                   input logic [K-1:0] pm,
                                   input logic [K-1:0] cm);
    logic res;
    case (sel)
      CMP_EQ:  res = (pm == cm);
      CMP_NEQ: res = (pm != cm);
      CMP_GT:  res = (pm >  cm);
      CMP_LT:  res = (pm <  cm);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [CFG_SIZE-1:0] r_cfg;
  logic [BC_W-1:0]     r_bitcnt;
  logic                r_done;

  // Serial config loader: shift in from the top so the first bit ends at bit 0.
  // Once the final bit arrives the image is locked until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg    <= '0;
      r_bitcnt <= '0;
      r_done   <= 1'b0;
    end else if (bitstreamValid && !r_done) begin
      r_cfg    <= {bitstreamSerialIn, r_cfg[CFG_SIZE-1:1]};
      r_bitcnt <= r_bitcnt + BC_W'(1);
      if (r_bitcnt == BC_W'(CFG_SIZE - 1)) begin
        r_done <= 1'b1;
      end
    end
  end

  assign cfgDone = r_done;

`ifndef SMU_STICKY_TRIGGER_EN
  logic w_unused_clr;
  assign w_unused_clr = ^trigClear;
`endif

  for (genvar m = 0; m < M; m++) begin : g_ch
    logic [S_W-1:0]       r_stage;
    logic [WIN_W-1:0]     r_win;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_trig;

    logic [UNIT_SIZE-1:0] w_unit;
    logic                 w_en;
    logic [1:0]           w_sel;
    logic                 w_last;
    logic [WIN_W-1:0]     w_window;
    logic [K-1:0]         w_mask;
    logic [K-1:0]         w_cmp;
    logic                 w_match;
    logic                 w_fire;
    logic [S_W-1:0]       w_stage_nxt;
    logic [WIN_W-1:0]     w_win_nxt;

    // Pick the config unit for this channel's current stage. Stage codes at or
    // above N are unreachable; they select an all-zero (disabled) unit.
    always_comb begin
      w_unit = '0;
      if (int'(r_stage) < N) begin
        w_unit = r_cfg[(int'(r_stage)*M + m)*UNIT_SIZE +: UNIT_SIZE];
      end else begin
        w_unit = '0;
      end
    end

    assign w_en     = w_unit[EN_O];
    assign w_sel    = w_unit[SEL_O +: 2];
    assign w_last   = w_unit[LAST_O];
    assign w_window = w_unit[WIN_O +: WIN_W];
    assign w_mask   = w_unit[MASK_O +: K];
    assign w_cmp    = w_unit[CMP_O +: K];
    assign w_match  = f_match(w_sel, p & w_mask, w_cmp & w_mask);

    // Sequence next-state. A match has priority over a window timeout.
    always_comb begin
      w_fire      = 1'b0;
      w_stage_nxt = r_stage;
      w_win_nxt   = r_win;
      if (!r_done) begin
        w_stage_nxt = '0;
        w_win_nxt   = '0;
      end else if (!w_en) begin
        w_stage_nxt = '0;
        w_win_nxt   = '0;
      end else if (w_match) begin
        w_win_nxt = '0;
        if (w_last || (r_stage == S_W'(N - 1))) begin
          w_fire      = 1'b1;
          w_stage_nxt = '0;
        end else begin
          w_stage_nxt = r_stage + S_W'(1);
        end
      end else if (r_stage == '0) begin
        w_win_nxt = '0;
      end else if (w_window == '0) begin
        w_win_nxt = r_win;
      end else if (r_win == (w_window - WIN_W'(1))) begin
        w_stage_nxt = '0;
        w_win_nxt   = '0;
      end else begin
        w_win_nxt = r_win + WIN_W'(1);
      end
    end

    // Channel state, trigger and saturating event counter.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_stage <= '0;
        r_win   <= '0;
        r_cnt   <= '0;
        r_trig  <= 1'b0;
      end else begin
        r_stage <= w_stage_nxt;
        r_win   <= w_win_nxt;
`ifdef SMU_STICKY_TRIGGER_EN
        r_trig  <= w_fire | (r_trig & ~trigClear[m]);
`else
        r_trig  <= w_fire;
`endif
        if (w_fire && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign trigger[m]                  = r_trig;
    assign smuState[m*S_W +: S_W]      = r_stage;
    assign eventCount[m*CNT_W +: CNT_W] = r_cnt;
  end

endmodule

// File: tb/tb_smu_seq_window.sv
module tb_smu_seq_window;

  localparam int N     = 2;
  localparam int K     = 4;
  localparam int M     = 2;
  localparam int WIN_W = 2;
  localparam int CNT_W = 4;
  localparam int UNIT  = 2*K + WIN_W + 4;
  localparam int CFG   = N*M*UNIT;
  localparam int SW    = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [K-1:0]         p = '0;
  logic                 bitstreamSerialIn = 1'b0;
  logic                 bitstreamValid = 1'b0;
  logic [M-1:0]         trigClear = '0;
  logic                 cfgDone;
  logic [M-1:0]         trigger;
  logic [M*SW-1:0]      smuState;
  logic [M*CNT_W-1:0]   eventCount;

  always #5 clk = ~clk;

  smu_seq_window #(.N(N), .K(K), .M(M), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .p(p),
    .bitstreamSerialIn(bitstreamSerialIn), .bitstreamValid(bitstreamValid),
    .trigClear(trigClear), .cfgDone(cfgDone), .trigger(trigger),
    .smuState(smuState), .eventCount(eventCount)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CFG-1:0] m_cfg;
  int             m_cnt;
  bit             m_done;
  int             m_stage [M];
  int             m_win   [M];
  int             m_ev    [M];
  bit             m_trig  [M];

  function automatic int field(input int s, input int m, input int off, input int w);
    logic [63:0] t;
    t = 64'(m_cfg) >> ((s*M + m)*UNIT + off);
    return int'(t & ((64'd1 << w) - 64'd1));
  endfunction

  task automatic model_reset();
    m_cfg = '0; m_cnt = 0; m_done = 0;
    for (int m = 0; m < M; m++) begin
      m_stage[m] = 0; m_win[m] = 0; m_ev[m] = 0; m_trig[m] = 0;
    end
  endtask

  task automatic model_edge(input int pv, input bit v, input bit b, input logic [M-1:0] clr);
    int s, en, sel, last, win, mask, cmp, a, c;
    bit hit, fire;
    for (int m = 0; m < M; m++) begin
      fire = 0;
      if (m_done) begin
        s    = m_stage[m];
        en   = field(s, m, 0, 1);
        sel  = field(s, m, 1, 2);
        last = field(s, m, 3, 1);
        win  = field(s, m, 4, WIN_W);
        mask = field(s, m, 4 + WIN_W, K);
        cmp  = field(s, m, 4 + WIN_W + K, K);
        a = pv & mask;
        c = cmp & mask;
        case (sel)
          0:       hit = (a == c);
          1:       hit = (a != c);
          2:       hit = (a > c);
          default: hit = (a < c);
        endcase
        if (en == 0) begin
          m_stage[m] = 0; m_win[m] = 0;
        end else if (hit) begin
          m_win[m] = 0;
          if (last == 1 || s == N - 1) begin
            fire = 1; m_stage[m] = 0;
            if (m_ev[m] < (1 << CNT_W) - 1) m_ev[m]++;
          end else begin
            m_stage[m] = s + 1;
          end
        end else if (s == 0) begin
          m_win[m] = 0;
        end else if (win != 0) begin
          if (m_win[m] == win - 1) begin
            m_stage[m] = 0; m_win[m] = 0;
          end else begin
            m_win[m]++;
          end
        end
`ifdef SMU_STICKY_TRIGGER_EN
        m_trig[m] = fire || (m_trig[m] && !clr[m]);
`else
        m_trig[m] = fire;
`endif
      end else begin
        m_stage[m] = 0; m_win[m] = 0; m_trig[m] = 0;
      end
    end
    if (v && !m_done) begin
      m_cfg[m_cnt] = b;
      m_cnt++;
      if (m_cnt == CFG) m_done = 1;
    end
  endtask

  task automatic check_outputs();
    logic [M-1:0]       et;
    logic [M*SW-1:0]    es;
    logic [M*CNT_W-1:0] ee;
    for (int m = 0; m < M; m++) begin
      et[m] = m_trig[m];
      es[m*SW +: SW] = SW'(m_stage[m]);
      ee[m*CNT_W +: CNT_W] = CNT_W'(m_ev[m]);
    end
    chk("cfgDone", cfgDone, m_done);
    chk("trigger", trigger, et);
    chk("smuState", smuState, es);
    chk("eventCount", eventCount, ee);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input int pv, input bit v, input bit b, input logic [M-1:0] clr);
    p = K'(pv); bitstreamValid = v; bitstreamSerialIn = b; trigClear = clr;
    @(posedge clk);
    model_edge(pv, v, b, clr);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_cfgDone", cfgDone, 1'b0);
    chk("rst_trigger", trigger, '0);
    chk("rst_state", smuState, '0);
    chk("rst_count", eventCount, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bitstreamValid = 1'b0;
    check_outputs();
  endtask

  task automatic load(input logic [CFG-1:0] c);
    for (int i = 0; i < CFG; i++) cycle(0, 1'b1, c[i], '0);
    bitstreamValid = 1'b0;
  endtask

  function automatic logic [CFG-1:0] set_unit(input logic [CFG-1:0] c, input int s, input int m,
      input int en, input int sel, input int last, input int win, input int mask, input int cmp);
    logic [UNIT-1:0] u;
    logic [CFG-1:0]  r;
    u = {K'(cmp), K'(mask), WIN_W'(win), 1'(last), 2'(sel), 1'(en)};
    r = c;
    r[(s*M + m)*UNIT +: UNIT] = u;
    return r;
  endfunction

  logic [CFG-1:0] cfg_a, cfg_b, cfg_r;

  initial begin
    do_reset();

    // Config A: ch0 = eq 3 -> eq 5 (Last, Window 2); ch1 = single-stage gt 7.
    cfg_a = '0;
    cfg_a = set_unit(cfg_a, 0, 0, 1, 0, 0, 0, 15, 3);
    cfg_a = set_unit(cfg_a, 1, 0, 1, 0, 1, 2, 15, 5);
    cfg_a = set_unit(cfg_a, 0, 1, 1, 2, 1, 0, 15, 7);
    for (int i = 0; i < CFG - 1; i++) cycle(0, 1'b1, cfg_a[i], '0);
    chk("cfg_partial", cfgDone, 1'b0);
    cycle(0, 1'b1, cfg_a[CFG-1], '0);
    chk("cfg_done", cfgDone, 1'b1);
    for (int i = 0; i < 6; i++) cycle(0, 1'b1, 1'($urandom), '0);
    bitstreamValid = 1'b0;

    cycle(3, 1'b0, 1'b0, '0);
    chk("seq_stage1", smuState[0 +: SW], 1);
    cycle(5, 1'b0, 1'b0, '0);
    chk("seq_trig", trigger[0], 1'b1);
    chk("seq_count", eventCount[0 +: CNT_W], 1);
    chk("seq_back0", smuState[0 +: SW], 0);

    // Timeout: the second idle cycle at stage 1 drops the sequence.
    cycle(3, 1'b0, 1'b0, '1);
    cycle(0, 1'b0, 1'b0, '0);
    chk("to_hold", smuState[0 +: SW], 1);
    cycle(0, 1'b0, 1'b0, '0);
    chk("to_expire", smuState[0 +: SW], 0);
    cycle(5, 1'b0, 1'b0, '1);
    chk("to_notrig", trigger[0], 1'b0);

    cycle(8, 1'b0, 1'b0, '0);
    chk("gt_fire", trigger[1], 1'b1);
    cycle(7, 1'b0, 1'b0, '1);

    // Config B: ch0 = lt 7, ch1 = neq 7, both single-stage.
    do_reset();
    cfg_b = '0;
    cfg_b = set_unit(cfg_b, 0, 0, 1, 3, 1, 0, 15, 7);
    cfg_b = set_unit(cfg_b, 0, 1, 1, 1, 1, 0, 15, 7);
    load(cfg_b);
    cycle(6, 1'b0, 1'b0, '0);
    chk("lt_neq_fire", trigger, 2'b11);
    cycle(7, 1'b0, 1'b0, '0);
    cycle(0, 1'b0, 1'b0, '0);
    chk("neq_zero", trigger[1], 1'b1);
    for (int i = 0; i < 20; i++) cycle(0, 1'b0, 1'b0, '0);
    chk("sat_ch1", eventCount[CNT_W +: CNT_W], 15);
    chk("sat_ch0", eventCount[0 +: CNT_W], 15);
`ifdef SMU_STICKY_TRIGGER_EN
    cycle(7, 1'b0, 1'b0, 2'b01);
    chk("sticky_clr", trigger, 2'b10);
    cycle(0, 1'b0, 1'b0, 2'b11);
    chk("sticky_fire_clr", trigger, 2'b11);
`endif

    // Reset in the middle of a sequence.
    do_reset();
    load(cfg_a);
    cycle(3, 1'b0, 1'b0, '0);
    chk("mid_stage1", smuState[0 +: SW], 1);
    do_reset();

    // Randomised rounds: random config, random bus, gaps in the bitstream,
    // random clears and occasional reset during load or monitoring.
    for (int r = 0; r < 5; r++) begin
      int idx;
      bit v, b;
      cfg_r = CFG'({$urandom, $urandom});
      for (int s = 0; s < N; s++)
        for (int m = 0; m < M; m++)
          cfg_r[(s*M + m)*UNIT] = ($urandom_range(0, 3) != 0);
      do_reset();
      idx = 0;
      for (int c = 0; c < 300; c++) begin
        v = ($urandom_range(0, 3) != 0);
        if (!m_done) begin
          b = cfg_r[idx];
          if (v) idx++;
        end else begin
          b = 1'($urandom);
        end
        if ($urandom_range(0, 199) == 0) begin
          do_reset();
          idx = 0;
        end else begin
          cycle($urandom_range(0, 15), v, b, M'($urandom));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
